// File: rtl/operand_bypass_mux_pkg.sv
// operand_bypass_mux_pkg: shared constants and entry type for the operand bypass unit
package operand_bypass_mux_pkg;
   localparam int REG_AW_DEF = 5;
   localparam int LAT_W_DEF  = 2;
   localparam int REG_ZERO   = 0;
   localparam int LAT_ALU    = 1;
   localparam int LAT_LOAD   = 2;
   typedef struct packed {
      logic                  v;
      logic [REG_AW_DEF-1:0] addr;
      logic [LAT_W_DEF-1:0]  rem;
   } bypass_entry_t;
endpackage

// File: rtl/operand_bypass_mux_if.sv
// operand_bypass_mux_if: decode-side issue/operand bus; stall_cnt exists only with BYPASS_PERF_EN
interface operand_bypass_mux_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int DEPTH   = 3,
   parameter int NUM_OPS = 2,
   parameter int LAT_W   = 2
);
   logic                      issue_valid;
   logic                      issue_wr;
   logic [REG_AW-1:0]         issue_addr;
   logic [LAT_W-1:0]          issue_lat;
   logic                      flush;
   logic [NUM_OPS*REG_AW-1:0] op_addr;
   logic [NUM_OPS*DATA_W-1:0] rf_rd;
   logic [DEPTH*DATA_W-1:0]   stage_data;
   logic [NUM_OPS*DATA_W-1:0] op_data;
   logic                      stall;
`ifdef BYPASS_PERF_EN
   logic [31:0]               stall_cnt;
   modport master (output issue_valid, issue_wr, issue_addr, issue_lat, flush, op_addr, rf_rd, stage_data,
                   input op_data, stall, stall_cnt);
   modport slave (input issue_valid, issue_wr, issue_addr, issue_lat, flush, op_addr, rf_rd, stage_data,
                  output op_data, stall, stall_cnt);
`else
   modport master (output issue_valid, issue_wr, issue_addr, issue_lat, flush, op_addr, rf_rd, stage_data,
                   input op_data, stall);
   modport slave (input issue_valid, issue_wr, issue_addr, issue_lat, flush, op_addr, rf_rd, stage_data,
                  output op_data, stall);
`endif
endinterface

// File: rtl/operand_bypass_mux_bypass_select.sv
// bypass_select: per-operand priority match over tracked writers; youngest match decides
module bypass_select
   import operand_bypass_mux_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3
) (
   input  logic [DEPTH-1:0]             ent_v,
   input  logic [DEPTH-1:0][REG_AW-1:0] ent_addr,
   input  logic [DEPTH-1:0]             ent_rdy,
   input  logic [REG_AW-1:0]            op_addr,
   input  logic [DATA_W-1:0]            rf_rd,
   input  logic [DEPTH-1:0][DATA_W-1:0] stage_data,
   output logic [DATA_W-1:0]            op_data,
   output logic                         blocked
);
   always_comb begin
      op_data = rf_rd;
      blocked = 1'b0;
      // oldest to youngest so the youngest match overrides, even when it is not ready
      for (int i = DEPTH - 1; i >= 0; i--)
         if (ent_v[i] && ent_addr[i] == op_addr) begin
            op_data = ent_rdy[i] ? stage_data[i] : rf_rd;
            blocked = ~ent_rdy[i];
         end
      if (op_addr == REG_AW'(REG_ZERO)) begin
         op_data = '0;
         blocked = 1'b0;
      end
   end
endmodule

// File: rtl/operand_bypass_mux.sv
// operand_bypass_mux: writer tracking shift register, operand forwarding and load-use stall.
// BYPASS_PERF_EN adds a 32-bit stall cycle counter on stall_cnt.
module operand_bypass_mux
   import operand_bypass_mux_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int DEPTH   = 3,
   parameter int NUM_OPS = 2,
   parameter int LAT_W   = 2
) (
   input logic clk,
   input logic reset,
   operand_bypass_mux_if.slave bus
);
   logic [DEPTH-1:0]             ent_v;
   logic [DEPTH-1:0][REG_AW-1:0] ent_addr;
   logic [DEPTH-1:0][LAT_W-1:0]  ent_rem;
   logic [DEPTH-1:0]             ent_rdy;
   logic [NUM_OPS-1:0]           blocked;

   always_comb
      for (int i = 0; i < DEPTH; i++)
         ent_rdy[i] = ent_rem[i] == '0;

   // older entries keep moving during a stall; only entry 0 takes the bubble
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ent_v    <= '0;
         ent_addr <= '0;
         ent_rem  <= '0;
      end else begin
         ent_v[0]    <= bus.issue_valid & bus.issue_wr & ~bus.stall & ~bus.flush &
                        (bus.issue_addr != REG_AW'(REG_ZERO));
         ent_addr[0] <= bus.issue_addr;
         ent_rem[0]  <= bus.issue_lat - LAT_W'(1);
         for (int i = 1; i < DEPTH; i++) begin
            ent_v[i]    <= ent_v[i-1];
            ent_addr[i] <= ent_addr[i-1];
            ent_rem[i]  <= ent_rdy[i-1] ? '0 : ent_rem[i-1] - LAT_W'(1);
         end
      end

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
      bypass_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_sel (
         .ent_v     (ent_v),
         .ent_addr  (ent_addr),
         .ent_rdy   (ent_rdy),
         .op_addr   (bus.op_addr[k*REG_AW +: REG_AW]),
         .rf_rd     (bus.rf_rd[k*DATA_W +: DATA_W]),
         .stage_data(bus.stage_data),
         .op_data   (bus.op_data[k*DATA_W +: DATA_W]),
         .blocked   (blocked[k])
      );
   end

   assign bus.stall = bus.issue_valid & ~bus.flush & (|blocked);

`ifdef BYPASS_PERF_EN
   always_ff @(posedge clk or posedge reset)
      if (reset)
         bus.stall_cnt <= '0;
      else if (bus.stall)
         bus.stall_cnt <= bus.stall_cnt + 32'd1;
`endif

   a_lat_nonzero: assert property (@(posedge clk) disable iff (reset)
      (bus.issue_valid && bus.issue_wr) |-> bus.issue_lat != '0);
endmodule

// File: tb/tb_operand_bypass_mux.sv
// tb_operand_bypass_mux: directed cases plus random traffic against a writer-age reference model
module tb_operand_bypass_mux;
   import operand_bypass_mux_pkg::*;
   localparam int DATA_W = 32, REG_AW = 5, DEPTH = 3, NUM_OPS = 2;

   typedef struct {int addr; int lat; int age;} writer_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   writer_t wq[$];
   logic [31:0] m_cnt = '0;

   operand_bypass_mux_if bus ();
   operand_bypass_mux dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // a writer of age a sits in stage a and its result exists once a >= lat-1
   task automatic model_eval(output logic [NUM_OPS*DATA_W-1:0] d, output logic st,
                             output logic [NUM_OPS-1:0] blk);
      st = 1'b0;
      for (int k = 0; k < NUM_OPS; k++) begin
         int a = int'(bus.op_addr[k*REG_AW +: REG_AW]);
         int best = -1;
         d[k*DATA_W +: DATA_W] = bus.rf_rd[k*DATA_W +: DATA_W];
         blk[k] = 1'b0;
         if (a == 0) d[k*DATA_W +: DATA_W] = '0;
         else begin
            foreach (wq[j])
               if (wq[j].addr == a && (best < 0 || wq[j].age < wq[best].age)) best = j;
            if (best >= 0) begin
               if (wq[best].age >= wq[best].lat - 1)
                  d[k*DATA_W +: DATA_W] = bus.stage_data[wq[best].age*DATA_W +: DATA_W];
               else blk[k] = 1'b1;
            end
         end
      end
      st = bus.issue_valid & ~bus.flush & (|blk);
   endtask

   task automatic advance(input logic st);
      writer_t nq[$];
      if (st) m_cnt++;
      foreach (wq[j])
         if (wq[j].age + 1 < DEPTH) nq.push_back('{wq[j].addr, wq[j].lat, wq[j].age + 1});
      if (bus.issue_valid && bus.issue_wr && !st && !bus.flush && bus.issue_addr != 0)
         nq.push_back('{int'(bus.issue_addr), int'(bus.issue_lat), 0});
      wq = nq;
   endtask

   task automatic tick();
      logic [NUM_OPS*DATA_W-1:0] ed;
      logic es;
      logic [NUM_OPS-1:0] blk;
      @(negedge clk);
      model_eval(ed, es, blk);
      chk("stall", 32'(bus.stall), 32'(es));
      for (int k = 0; k < NUM_OPS; k++)
         if (!blk[k]) chk($sformatf("op_data%0d", k), bus.op_data[k*DATA_W +: DATA_W], ed[k*DATA_W +: DATA_W]);
`ifdef BYPASS_PERF_EN
      chk("stall_cnt", bus.stall_cnt, m_cnt);
`endif
      @(posedge clk);
      advance(es);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
      for (int k = 0; k < NUM_OPS; k++)
         chk($sformatf("%s_op%0d", tag, k), bus.op_data[k*DATA_W +: DATA_W],
             bus.op_addr[k*REG_AW +: REG_AW] == 0 ? 32'd0 : bus.rf_rd[k*DATA_W +: DATA_W]);
`ifdef BYPASS_PERF_EN
      chk({tag, "_cnt"}, bus.stall_cnt, 32'd0);
`endif
   endtask

   // reset pulse between clock edges, released on the next falling edge
   task automatic async_reset();
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst");
      wq.delete();
      m_cnt = '0;
      @(negedge clk) reset = 1'b0;
      @(posedge clk) advance(1'b0);
      #1;
   endtask

   task automatic set(input logic v, input logic wr, input int addr, input int lat, input logic fl,
                      input int op0, input int op1);
      bus.issue_valid = v;
      bus.issue_wr    = wr;
      bus.issue_addr  = REG_AW'(addr);
      bus.issue_lat   = 2'(lat);
      bus.flush       = fl;
      bus.op_addr     = {REG_AW'(op1), REG_AW'(op0)};
   endtask

   function automatic logic [31:0] od(input int k);
      return bus.op_data[k*DATA_W +: DATA_W];
   endfunction

   localparam logic [DEPTH*DATA_W-1:0] STAGES = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
   localparam logic [31:0] RF0 = 32'h1111_1111;

   initial begin
`ifdef BYPASS_PERF_EN
      logic [31:0] snap;
`endif
      bus.rf_rd = {32'h2222_2222, RF0};
      bus.stage_data = STAGES;
      set(0, 0, 0, LAT_ALU, 0, 8, 9);
      #2 check_reset_outputs("init");
      @(posedge clk) #1 reset = 1'b0;

      set(1, 1, 8, LAT_ALU, 0, 3, 4);               tick();
      set(0, 0, 0, LAT_ALU, 0, 8, 4);               #1 chk("alu_fwd", od(0), 32'hAAAA_0000);
      chk("alu_nostall", 32'(bus.stall), 32'd0);    tick();

      set(1, 1, 9, LAT_LOAD, 0, 3, 4);              tick();
      set(1, 0, 0, LAT_ALU, 0, 3, 9);               #1 chk("lu_stall", 32'(bus.stall), 32'd1);
      tick();
      #1 chk("lu_release", 32'(bus.stall), 32'd0);
      chk("lu_fwd", od(1), 32'hBBBB_0001);          tick();

      set(1, 1, 10, LAT_ALU, 0, 3, 4);              tick();
      set(0, 0, 0, LAT_ALU, 0, 3, 4);               tick();
      set(1, 1, 10, LAT_ALU, 0, 3, 4);              tick();
      set(1, 0, 0, LAT_ALU, 0, 10, 4);              #1 chk("shadow_fwd", od(0), 32'hAAAA_0000);
      tick();

      set(1, 1, 10, LAT_ALU, 0, 3, 4);              tick();
      set(0, 0, 0, LAT_ALU, 0, 3, 4);               tick();
      set(1, 1, 10, LAT_LOAD, 0, 3, 4);             tick();
      set(1, 0, 0, LAT_ALU, 0, 10, 4);              #1 chk("shadow_stall", 32'(bus.stall), 32'd1);
      tick();
      #1 chk("shadow_young", od(0), 32'hBBBB_0001); tick();

      bus.stage_data = {DEPTH{32'hDEAD_BEEF}};
      set(1, 1, 0, LAT_ALU, 0, 3, 4);               tick();
      set(1, 0, 0, LAT_ALU, 0, 0, 4);               #1 chk("zero_data", od(0), 32'd0);
      chk("zero_stall", 32'(bus.stall), 32'd0);     tick();
      bus.stage_data = STAGES;

      set(1, 1, 11, LAT_LOAD, 0, 3, 4);             tick();
      set(1, 1, 12, LAT_ALU, 1, 11, 4);             #1 chk("flush_stall", 32'(bus.stall), 32'd0);
`ifdef BYPASS_PERF_EN
      snap = bus.stall_cnt;
`endif
      tick();
      set(0, 0, 0, LAT_ALU, 0, 12, 4);              #1 chk("flush_bubble", od(0), RF0);
`ifdef BYPASS_PERF_EN
      chk("flush_cnt", bus.stall_cnt, snap);
`endif
      tick();

      set(1, 1, 9, LAT_LOAD, 0, 3, 4);              tick();
      set(1, 0, 0, LAT_ALU, 0, 9, 4);               #1 chk("rst_pre", 32'(bus.stall), 32'd1);
      async_reset();
      #1 chk("rst_nofwd", od(0), RF0);
      chk("rst_nostall", 32'(bus.stall), 32'd0);    tick();

      for (int n = 0; n < 2000; n++) begin
         bus.rf_rd      = {$urandom, $urandom};
         bus.stage_data = {$urandom, $urandom, $urandom};
         set($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
             $urandom_range(LAT_ALU, LAT_LOAD), $urandom_range(0, 7) == 0,
             $urandom_range(0, 7), $urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) async_reset();
         else tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
